// File: rtl/five_bit_compare_sequencer.sv
// Bit-serial magnitude comparator: scans captured operands MSB-first, one bit per clock.
// Build option EARLY_EXIT_EN: stop scanning at the first differing bit instead of bit 0.
module five_bit_compare_sequencer #(
    parameter int WIDTH = 5,
    parameter int CNTW  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             ready,
    output logic             done,
    output logic             E,
    output logic             L,
    output logic             G,
    output logic [CNTW-1:0]  bits_used,
    output logic [1:0]       state_dbg
);

    localparam int IDXW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    // Handshake: a request is taken on any rising edge where start=1 and ready=1;
    // A/B are sampled on that edge only, and done pulses for one cycle per result.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
    logic              eq_q, eq_d, lt_q, lt_d, gt_q, gt_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic              e_q, e_d, l_q, l_d, g_q, g_d;
    logic [CNTW-1:0]   bits_q, bits_d;

    logic              a_bit, b_bit, bit_differs;
    logic              eq_nx, lt_nx, gt_nx;
    logic [CNTW-1:0]   cnt_nx;
    logic              last_step;
    logic              accept;

    // One shared bit-slice step: flags only move while still equal so far.
    assign a_bit       = a_q[idx_q];
    assign b_bit       = b_q[idx_q];
    assign bit_differs = a_bit ^ b_bit;
    assign eq_nx       = eq_q & ~bit_differs;
    assign gt_nx       = gt_q | (eq_q & a_bit & ~b_bit);
    assign lt_nx       = lt_q | (eq_q & ~a_bit & b_bit);
    assign cnt_nx      = cnt_q + CNTW'(1);
    assign accept      = start && (state_q == S_IDLE || state_q == S_DONE);

`ifdef EARLY_EXIT_EN
    assign last_step = (idx_q == '0) || (eq_q && bit_differs);
`else
    assign last_step = (idx_q == '0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
            gt_q    <= 1'b0;
            idx_q   <= '0;
            cnt_q   <= '0;
            e_q     <= 1'b0;
            l_q     <= 1'b0;
            g_q     <= 1'b0;
            bits_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            eq_q    <= eq_d;
            lt_q    <= lt_d;
            gt_q    <= gt_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            e_q     <= e_d;
            l_q     <= l_d;
            g_q     <= g_d;
            bits_q  <= bits_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        eq_d    = eq_q;
        lt_d    = lt_q;
        gt_d    = gt_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        e_d     = e_q;
        l_d     = l_q;
        g_d     = g_q;
        bits_d  = bits_q;

        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_SCAN;
            end
            S_SCAN: begin
                eq_d  = eq_nx;
                lt_d  = lt_nx;
                gt_d  = gt_nx;
                cnt_d = cnt_nx;
                idx_d = idx_q - IDXW'(1);
                if (last_step) begin
                    e_d     = eq_nx;
                    l_d     = lt_nx;
                    g_d     = gt_nx;
                    bits_d  = cnt_nx;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = start ? S_SCAN : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Capture is shared by IDLE and DONE so back-to-back requests lose no cycle.
        if (accept) begin
            a_d   = A;
            b_d   = B;
            eq_d  = 1'b1;
            lt_d  = 1'b0;
            gt_d  = 1'b0;
            idx_d = IDXW'(WIDTH - 1);
            cnt_d = '0;
        end
    end

    always_comb begin
        ready     = (state_q == S_IDLE) || (state_q == S_DONE);
        done      = (state_q == S_DONE);
        state_dbg = state_q;
    end

    assign E         = e_q;
    assign L         = l_q;
    assign G         = g_q;
    assign bits_used = bits_q;

endmodule

// File: tb/tb_five_bit_compare_sequencer.sv
// Self-checking bench for five_bit_compare_sequencer: directed table, corner sequences, random vs model.
module tb_five_bit_compare_sequencer;

    localparam int W = 5;
    localparam int C = 5;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         ready, done, E, L, G;
    logic [C-1:0] bits_used;
    logic [1:0]   state_dbg;

    int checks = 0;
    int errors = 0;

    five_bit_compare_sequencer #(.WIDTH(W), .CNTW(C)) dut (
        .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
        .ready(ready), .done(done), .E(E), .L(L), .G(G),
        .bits_used(bits_used), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string        name;
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           e;
        int           l;
        int           g;
        int           bits;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Number of bits examined: first differing position counted from the MSB.
    function automatic int model_bits(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef EARLY_EXIT_EN
        logic [W-1:0] d;
        d = a ^ b;
        if (d == 0) return W;
        for (int i = W - 1; i >= 0; i--) if (d[i]) return W - i;
        return W;
`else
        return W;
`endif
    endfunction

    // Waits for done after an accepting edge; ready must stay low until then.
    task automatic wait_done(input string name, output int lat);
        bit seen;
        seen = 0;
        lat  = 0;
        while (!seen && lat < W + 4) begin
            @(posedge clk); #1;
            lat++;
            if (done) seen = 1;
            else check({name, "_ready_low"}, int'(ready), 0);
        end
        if (!seen) check({name, "_timeout"}, 0, 1);
    endtask

    task automatic run_one(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                           input int ee, input int el, input int eg, input int ebits);
        int lat;
        check({name, "_ready_before"}, int'(ready), 1);
        A = a; B = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        A = W'($urandom);
        B = W'($urandom);
        wait_done(name, lat);
        check({name, "_latency"}, lat, ebits);
        check({name, "_E"}, int'(E), ee);
        check({name, "_L"}, int'(L), el);
        check({name, "_G"}, int'(G), eg);
        check({name, "_bits"}, int'(bits_used), ebits);
        @(posedge clk); #1;
        check({name, "_done_pulse"}, int'(done), 0);
        check({name, "_held_E"}, int'(E), ee);
    endtask

    initial begin
        int lat;
        logic [W-1:0] ra, rb;

`ifdef EARLY_EXIT_EN
        vecs[0] = '{"equal",     5'b10110, 5'b10110, 1, 0, 0, 5};
        vecs[1] = '{"msb",       5'b10000, 5'b01111, 0, 0, 1, 1};
        vecs[2] = '{"lsb",       5'b00010, 5'b00011, 0, 1, 0, 5};
        vecs[3] = '{"bit3",      5'd3,     5'd9,     0, 1, 0, 2};
        vecs[4] = '{"max_zero",  5'd31,    5'd0,     0, 0, 1, 1};
        vecs[5] = '{"zero_zero", 5'd0,     5'd0,     1, 0, 0, 5};
        vecs[6] = '{"one_zero",  5'd1,     5'd0,     0, 0, 1, 5};
`else
        vecs[0] = '{"equal",     5'b10110, 5'b10110, 1, 0, 0, 5};
        vecs[1] = '{"msb",       5'b10000, 5'b01111, 0, 0, 1, 5};
        vecs[2] = '{"lsb",       5'b00010, 5'b00011, 0, 1, 0, 5};
        vecs[3] = '{"bit3",      5'd3,     5'd9,     0, 1, 0, 5};
        vecs[4] = '{"max_zero",  5'd31,    5'd0,     0, 0, 1, 5};
        vecs[5] = '{"zero_zero", 5'd0,     5'd0,     1, 0, 0, 5};
        vecs[6] = '{"one_zero",  5'd1,     5'd0,     0, 0, 1, 5};
`endif

        // Reset and idle
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_ready", int'(ready), 1);
        check("rst_done", int'(done), 0);
        check("rst_E", int'(E), 0);
        check("rst_L", int'(L), 0);
        check("rst_G", int'(G), 0);
        check("rst_bits", int'(bits_used), 0);
        @(posedge clk); #1;
        check("idle_ready", int'(ready), 1);

        // Directed table; operands are scrambled right after each accept
        for (int i = 0; i < 7; i++)
            run_one(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].e, vecs[i].l, vecs[i].g, vecs[i].bits);

        // Ignored mid-SCAN start, then back-to-back accept in the DONE cycle
        A = 5'd3; B = 5'd9; start = 1'b1;
        @(posedge clk); #1;
        A = 5'd9; B = 5'd3;
        @(posedge clk); #1;
        check("b2b_midscan_ready", int'(ready), 0);
        start = 1'b0; A = '0; B = '0;
        wait_done("b2b_first", lat);
        check("b2b_first_latency", lat + 1, model_bits(5'd3, 5'd9));
        check("b2b_first_L", int'(L), 1);
        check("b2b_first_G", int'(G), 0);
        check("b2b_first_E", int'(E), 0);
        A = 5'd31; B = 5'd0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; A = '0; B = '0;
        check("b2b_no_idle_ready", int'(ready), 0);
        check("b2b_no_idle_done", int'(done), 0);
        check("b2b_hold_L", int'(L), 1);
        wait_done("b2b_second", lat);
        check("b2b_second_latency", lat, model_bits(5'd31, 5'd0));
        check("b2b_second_G", int'(G), 1);
        check("b2b_second_L", int'(L), 0);
        check("b2b_second_bits", int'(bits_used), model_bits(5'd31, 5'd0));
        @(posedge clk); #1;
        check("b2b_done_pulse", int'(done), 0);

        // Reset during the second SCAN cycle aborts the compare
        A = 5'd7; B = 5'd8; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rstscan_done", int'(done), 0);
        check("rstscan_ready", int'(ready), 1);
        check("rstscan_E", int'(E), 0);
        check("rstscan_L", int'(L), 0);
        check("rstscan_G", int'(G), 0);
        check("rstscan_bits", int'(bits_used), 0);
        for (int i = 0; i < W + 2; i++) begin
            @(posedge clk); #1;
            check("rstscan_no_done", int'(done), 0);
        end

        // Random operands against the reference model
        for (int i = 0; i < 60; i++) begin
            ra = W'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? ra : W'($urandom);
            run_one("rand", ra, rb, int'(ra == rb), int'(ra < rb), int'(ra > rb), model_bits(ra, rb));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
